// File: rtl/eq_biquad_scheduler_pkg.sv
// Shared Q-format constants, saturation limits, config select codes and FSM states
// for the time-multiplexed biquad equalizer.
package eq_biquad_scheduler_pkg;

    localparam int decim = 14;
    localparam int magn  = 8;
    localparam int N     = decim + magn + 1;
    localparam int NTAPS = 5;

    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    localparam logic [2:0] SEL_B0   = 3'd0;
    localparam logic [2:0] SEL_B1   = 3'd1;
    localparam logic [2:0] SEL_B2   = 3'd2;
    localparam logic [2:0] SEL_A1   = 3'd3;
    localparam logic [2:0] SEL_A2   = 3'd4;
    localparam logic [2:0] SEL_GAIN = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAP  = 2'd1,
        ST_GAIN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/eq_biquad_scheduler_mac.sv
// Shared signed N x N multiplier with a wide accumulator; the product is also exported
// so the scheduler can reuse the multiplier for the gain stage.
module eq_biquad_scheduler_mac
    import eq_biquad_scheduler_pkg::*;
#(
    parameter int ACC_W = 2 * N + 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    add,
    input  logic signed [N-1:0]     a,
    input  logic signed [N-1:0]     b,
    output logic signed [2*N-1:0]   prod,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;

    assign a_ext = {{N{a[N-1]}}, a};
    assign b_ext = {{N{b[N-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
        end
    end

endmodule

// File: rtl/eq_biquad_scheduler.sv
// Runs NUM_BANDS biquad bands one product per cycle on a single MAC, weights each band
// by its gain and emits the summed, saturated equalized sample.
module eq_biquad_scheduler
    import eq_biquad_scheduler_pkg::*;
#(
    parameter  int NUM_BANDS = 4,
    localparam int BW        = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic signed [N-1:0] DataIn,
    output logic signed [N-1:0] DataOut,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clr,
    input  logic                cfg_we,
    input  logic [BW-1:0]       cfg_band,
    input  logic [2:0]          cfg_sel,
    input  logic signed [N-1:0] cfg_data,
    output logic                cfg_ready
);

    localparam int ACC_W = 2 * N + 3;
    localparam int SUM_W = 2 * N + BW + 1;
    localparam int WIDE  = 2 * N + BW + 3;

    function automatic logic signed [N-1:0] sat_n(input logic signed [WIDE-1:0] v);
        logic signed [WIDE-1:0] hi;
        logic signed [WIDE-1:0] lo;
        hi = {{(WIDE-N){SAT_MAX[N-1]}}, SAT_MAX};
        lo = {{(WIDE-N){SAT_MIN[N-1]}}, SAT_MIN};
        if (v > hi)      sat_n = SAT_MAX;
        else if (v < lo) sat_n = SAT_MIN;
        else             sat_n = v[N-1:0];
    endfunction

    state_t                  state, state_nx;
    logic [BW-1:0]           band;
    logic [2:0]              tap;
    logic signed [N-1:0]     coef [NUM_BANDS][NTAPS];
    logic signed [N-1:0]     gain [NUM_BANDS];
    logic signed [N-1:0]     u, u1, u2;
    logic signed [N-1:0]     y1 [NUM_BANDS];
    logic signed [N-1:0]     y2 [NUM_BANDS];
    logic signed [SUM_W-1:0] sum;
    logic signed [N-1:0]     mac_a, mac_b;
    logic                    mac_clr, mac_add;
    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [SUM_W-1:0] sum_sh;
    logic signed [N-1:0]     yk;
    logic                    last_band;
    logic                    band_ok;
    logic                    cfg_hit;

    assign busy      = (state != ST_IDLE);
    assign cfg_ready = (state == ST_IDLE);
    assign last_band = (band == BW'(NUM_BANDS - 1));
    assign acc_sh    = acc >>> decim;
    assign sum_sh    = sum >>> decim;
    assign yk        = sat_n({{(WIDE-ACC_W){acc_sh[ACC_W-1]}}, acc_sh});

    if ((2 ** BW) == NUM_BANDS) begin : g_band_full
        assign band_ok = 1'b1;
    end else begin : g_band_part
        assign band_ok = (cfg_band < BW'(NUM_BANDS));
    end
    assign cfg_hit = cfg_we && cfg_ready && band_ok;

    eq_biquad_scheduler_mac #(.ACC_W(ACC_W)) u_mac (
        .clock (clock),
        .reset (reset),
        .clr   (mac_clr),
        .add   (mac_add),
        .a     (mac_a),
        .b     (mac_b),
        .prod  (prod),
        .acc   (acc)
    );

    // The gain stage borrows the multiplier: yk * gain is taken from prod while acc clears.
    always_comb begin
        state_nx = state;
        mac_a    = '0;
        mac_b    = '0;
        mac_clr  = 1'b0;
        mac_add  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_valid) begin
                    state_nx = ST_TAP;
                    mac_clr  = 1'b1;
                end
            end
            ST_TAP: begin
                mac_add = 1'b1;
                mac_a   = coef[band][tap];
                case (tap)
                    3'd0:    mac_b = u;
                    3'd1:    mac_b = u1;
                    3'd2:    mac_b = u2;
                    3'd3:    mac_b = y1[band];
                    default: mac_b = y2[band];
                endcase
                if (tap == 3'(NTAPS - 1)) state_nx = ST_GAIN;
            end
            ST_GAIN: begin
                mac_a    = yk;
                mac_b    = gain[band];
                mac_clr  = 1'b1;
                state_nx = last_band ? ST_DONE : ST_TAP;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            band      <= '0;
            tap       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= (state == ST_DONE);
            if (sample_valid && busy) overrun <= 1'b1;
            else if (overrun_clr)     overrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    band <= '0;
                    tap  <= '0;
                end
                ST_TAP:  tap  <= (tap == 3'(NTAPS - 1)) ? 3'd0 : tap + 3'd1;
                ST_GAIN: band <= band + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain[b] <= '0;
                for (int t = 0; t < NTAPS; t++) coef[b][t] <= '0;
            end
        end else if (cfg_hit) begin
            if (cfg_sel <= SEL_A2)        coef[cfg_band][cfg_sel] <= cfg_data;
            else if (cfg_sel == SEL_GAIN) gain[cfg_band]          <= cfg_data;
        end
    end

    // Input history shifts only once a sample completes, so all bands see the same u1/u2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            u       <= '0;
            u1      <= '0;
            u2      <= '0;
            sum     <= '0;
            DataOut <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                y1[b] <= '0;
                y2[b] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        u   <= DataIn;
                        sum <= '0;
                    end
                end
                ST_GAIN: begin
                    y2[band] <= y1[band];
                    y1[band] <= yk;
                    sum      <= sum + {{(SUM_W-2*N){prod[2*N-1]}}, prod};
                end
                ST_DONE: begin
                    DataOut <= sat_n({{(WIDE-SUM_W){sum_sh[SUM_W-1]}}, sum_sh});
                    u2      <= u1;
                    u1      <= u;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_biquad_scheduler.sv
// Directed bench for eq_biquad_scheduler: an arithmetic reference model predicts every
// equalized sample, plus literal expectations for the hand-worked cases.
module tb_eq_biquad_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [22:0] DataIn = '0;
    logic [22:0] DataOut;
    logic        out_valid, busy, overrun, cfg_ready;
    logic        overrun_clr = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_band = '0;
    logic [2:0]  cfg_sel = '0;
    logic [22:0] cfg_data = '0;

    int total = 0;
    int bad   = 0;

    longint      mcoef [4][5];
    longint      mgain [4];
    longint      my1 [4];
    longint      my2 [4];
    longint      mu1, mu2;
    logic [22:0] expq [$];

    eq_biquad_scheduler #(.NUM_BANDS(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .DataIn       (DataIn),
        .DataOut      (DataOut),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .cfg_we       (cfg_we),
        .cfg_band     (cfg_band),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint msat(input longint v);
        if (v > 64'sd4194303)  return 64'sd4194303;
        if (v < -64'sd4194304) return -64'sd4194304;
        return v;
    endfunction

    function automatic longint sx(input logic [22:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            mgain[b] = 0;
            my1[b]   = 0;
            my2[b]   = 0;
            for (int t = 0; t < 5; t++) mcoef[b][t] = 0;
        end
        mu1 = 0;
        mu2 = 0;
        expq.delete();
    endtask

    task automatic model_cfg(input int b, input int s, input logic [22:0] d);
        if (s < 5)       mcoef[b][s] = sx(d);
        else if (s == 5) mgain[b]    = sx(d);
    endtask

    // Difference equation per band in Q14, floor shift, then gain-weighted sum.
    function automatic logic [22:0] model_step(input logic [22:0] x);
        longint u, acc, yk, sum, r;
        u   = sx(x);
        sum = 0;
        for (int b = 0; b < 4; b++) begin
            acc = mcoef[b][0] * u + mcoef[b][1] * mu1 + mcoef[b][2] * mu2
                + mcoef[b][3] * my1[b] + mcoef[b][4] * my2[b];
            yk     = msat(acc >>> 14);
            my2[b] = my1[b];
            my1[b] = yk;
            sum    = sum + yk * mgain[b];
        end
        mu2 = mu1;
        mu1 = u;
        r   = msat(sum >>> 14);
        return r[22:0];
    endfunction

    always @(negedge clock) begin
        logic [22:0] ev;
        if (out_valid === 1'b1) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: DataOut %0h, expected no pulse", DataOut);
            end else begin
                ev = expq.pop_front();
                chk("dataout_vs_model", {9'b0, DataOut}, {9'b0, ev});
            end
        end
    end

    task automatic cfg_write(input int b, input int s, input logic [22:0] d);
        cfg_we   = 1'b1;
        cfg_band = b[1:0];
        cfg_sel  = s[2:0];
        cfg_data = d;
        @(negedge clock);
        cfg_we = 1'b0;
        model_cfg(b, s, d);
    endtask

    task automatic run_sample(input logic [22:0] x, input int inj_at, input int clr_at,
                              input int cfg_at, input int sim_sel, input logic [22:0] sim_data,
                              output logic [22:0] mexp);
        int e;
        bit seen;
        sample_valid = 1'b1;
        DataIn       = x;
        if (sim_sel >= 0) begin
            cfg_we   = 1'b1;
            cfg_band = 2'd0;
            cfg_sel  = sim_sel[2:0];
            cfg_data = sim_data;
            model_cfg(0, sim_sel, sim_data);
        end
        mexp = model_step(x);
        expq.push_back(mexp);
        @(negedge clock);
        sample_valid = 1'b0;
        cfg_we       = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        chk("cfg_ready_busy", {31'b0, cfg_ready}, 32'd0);
        e    = 0;
        seen = 1'b0;
        while (!seen && e < 40) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                sample_valid = (e == inj_at);
                overrun_clr  = (e == clr_at);
                cfg_we       = (e == cfg_at);
                if (e == inj_at) DataIn = 23'h123456;
                if (e == cfg_at) begin
                    cfg_band = 2'd0;
                    cfg_sel  = 3'd0;
                    cfg_data = 23'h0FFFFF;
                end
                @(negedge clock);
                e++;
                sample_valid = 1'b0;
                overrun_clr  = 1'b0;
                cfg_we       = 1'b0;
            end
        end
        chk("latency", e, 32'd25);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        chk("cfg_ready_after_done", {31'b0, cfg_ready}, 32'd1);
        @(negedge clock);
        chk("out_valid_one_cycle", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] m;
        logic [22:0] imp_in  [4];
        logic [22:0] imp_out [4];
        bit          seen;
        imp_in  = '{23'h004000, 23'h000000, 23'h000000, 23'h000000};
        imp_out = '{23'h004000, 23'h002000, 23'h001000, 23'h000800};
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        chk("reset_dataout", {9'b0, DataOut}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_overrun", {31'b0, overrun}, 32'd0);
        chk("reset_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        run_sample(23'h012345, -1, -1, -1, -1, '0, m);
        chk("zero_coef_model", {9'b0, m}, 32'd0);
        chk("zero_coef_dut", {9'b0, DataOut}, 32'd0);

        cfg_write(0, 0, 23'h004000);
        cfg_write(0, 5, 23'h004000);
        run_sample(23'h001000, -1, -1, -1, -1, '0, m);
        chk("unity_model", {9'b0, m}, 32'h001000);
        chk("unity_dut", {9'b0, DataOut}, 32'h001000);
        run_sample(23'h000000, -1, -1, -1, -1, '0, m);
        run_sample(23'h000000, -1, -1, -1, -1, '0, m);

        cfg_write(0, 3, 23'h002000);
        for (int i = 0; i < 4; i++) begin
            run_sample(imp_in[i], -1, -1, -1, -1, '0, m);
            chk("impulse_model", {9'b0, m}, {9'b0, imp_out[i]});
            chk("impulse_dut", {9'b0, DataOut}, {9'b0, imp_out[i]});
        end

        cfg_write(0, 3, 23'h000000);
        cfg_write(0, 0, 23'h1FC000);
        cfg_write(1, 0, 23'h1FC000);
        cfg_write(1, 5, 23'h004000);
        run_sample(23'h010000, -1, -1, -1, -1, '0, m);
        chk("sat_pos_model", {9'b0, m}, 32'h3FFFFF);
        chk("sat_pos_dut", {9'b0, DataOut}, 32'h3FFFFF);
        run_sample(23'h7F0000, -1, -1, -1, -1, '0, m);
        chk("sat_neg_model", {9'b0, m}, 32'h400000);
        chk("sat_neg_dut", {9'b0, DataOut}, 32'h400000);

        cfg_write(0, 0, 23'h004000);
        cfg_write(1, 0, 23'h000000);
        cfg_write(1, 5, 23'h000000);
        chk("overrun_before", {31'b0, overrun}, 32'd0);
        run_sample(23'h002000, 2, -1, 5, -1, '0, m);
        chk("overrun_set", {31'b0, overrun}, 32'd1);
        chk("overrun_result_dut", {9'b0, DataOut}, 32'h002000);
        run_sample(23'h001000, -1, -1, -1, -1, '0, m);
        chk("busy_write_ignored", {9'b0, DataOut}, 32'h001000);
        run_sample(23'h000800, 4, 4, -1, -1, '0, m);
        chk("overrun_set_wins", {31'b0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        @(negedge clock);
        overrun_clr = 1'b0;
        chk("overrun_cleared", {31'b0, overrun}, 32'd0);

        run_sample(23'h001000, -1, -1, -1, 5, 23'h008000, m);
        chk("same_cycle_cfg_model", {9'b0, m}, 32'h002000);
        chk("same_cycle_cfg_dut", {9'b0, DataOut}, 32'h002000);

        sample_valid = 1'b1;
        DataIn       = 23'h001000;
        @(negedge clock);
        sample_valid = 1'b0;
        @(negedge clock);
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_dataout", {9'b0, DataOut}, 32'd0);
        chk("midrst_overrun", {31'b0, overrun}, 32'd0);
        chk("midrst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_out_valid", {31'b0, seen}, 32'd0);
        cfg_write(0, 0, 23'h004000);
        cfg_write(0, 5, 23'h004000);
        run_sample(23'h001000, -1, -1, -1, -1, '0, m);
        chk("after_reset_model", {9'b0, m}, 32'h001000);
        chk("after_reset_dut", {9'b0, DataOut}, 32'h001000);

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
